result_pipe: RTL and testbench

- Parametrised, elastic successor to the single ALU result holding register.
- Carries a WIDTH-bit datapath result through DEPTH register stages under a valid/ready handshake, with stall, flush and occupancy reporting.
- Sits between the ALU and the writeback/memory-address consumers of the multi-cycle CPU.
- Lets the control FSM stall or squash in-flight results instead of relying on an unconditional per-clock latch.

---
 rtl/result_pipe.sv | 98 +++++++++
 tb/tb_result_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pipe.sv
// Elastic DEPTH-stage result pipe with valid/ready handshake, flush and occupancy.
// Optional per-stage parity is enabled by defining RESULT_PIPE_PARITY_EN.
module result_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       err_inj,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       out_perr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_src;
    logic [DEPTH-1:0]            v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] d_src;
    logic [DEPTH:0]              r;
    logic [OW-1:0]               cnt;

    // Ready ripples back from the output; an empty stage is always ready,
    // which is what lets bubbles collapse under backpressure.
    always_comb begin
        r        = '0;
        v_src    = '0;
        d_src    = '0;
        v_nxt    = '0;
        cnt      = '0;
        r[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--)
            r[k] = ~v[k] | r[k+1];
        in_ready = r[0] & ~flush;
        v_src[0] = in_valid & in_ready;
        d_src[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            v_src[k] = v[k-1];
            d_src[k] = d[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            v_nxt[k] = flush ? 1'b0 : (r[k] ? v_src[k] : v[k]);
            cnt      = cnt + OW'(v_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= '0;
            d         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= cnt;
            for (int k = 0; k < DEPTH; k++)
                if (r[k]) d[k] <= d_src[k];
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef RESULT_PIPE_PARITY_EN
    logic [DEPTH-1:0] p;
    logic [DEPTH-1:0] p_src;

    always_comb begin
        p_src    = '0;
        p_src[0] = ^in_data ^ err_inj;
        for (int k = 1; k < DEPTH; k++)
            p_src[k] = p[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (flush)     p[k] <= 1'b0;
                else if (r[k]) p[k] <= p_src[k];
        end
    end

    assign out_perr = out_valid & (p[DEPTH-1] != ^out_data);
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign out_perr       = 1'b0;
`endif

endmodule

// File: tb/tb_result_pipe.sv
// Scoreboard bench for result_pipe: DEPTH=2 instance under a queue-driven
// output monitor, plus a DEPTH=4 instance for bubble-collapse checks.
module tb_result_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, err_inj;
    logic        out_valid, out_ready, out_perr;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_perr4;
    logic        flush4 = 1'b0;
    logic [31:0] in_data4, out_data4;
    logic [2:0]  occupancy4;

    typedef struct packed {
        logic [31:0] data;
        logic        perr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [31:0] stream [3] = '{32'h11, 32'h22, 32'h33};
    logic        s_ov   [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0]  s_oc   [3] = '{2'd0, 2'd1, 2'd2};

    always #5 clk = ~clk;

    result_pipe #(.WIDTH(32), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .err_inj(err_inj),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_perr(out_perr), .occupancy(occupancy)
    );

    result_pipe #(.WIDTH(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .flush(flush4), .err_inj(err_inj),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
        .out_perr(out_perr4), .occupancy(occupancy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic inj);
`ifdef RESULT_PIPE_PARITY_EN
        return inj;
`else
        return 1'b0 & inj;
`endif
    endfunction

    task automatic push(input logic [31:0] dat, input logic inj);
        exp_t e;
        e.data = dat;
        e.perr = exp_perr(inj);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got 0x%0h, want no output", out_data);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_perr", 32'(out_perr), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        flush = 1'b0; err_inj = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;

        // reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_perr", 32'(out_perr), 32'd0);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        step();

        // streaming, out_ready high
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = stream[i]; push(stream[i], 1'b0);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_out_valid", 32'(out_valid), 32'(s_ov[i]));
            chk("stream_occ", 32'(occupancy), 32'(s_oc[i]));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_occ_full", 32'(occupancy), 32'd2);
        step(); step();
        @(negedge clk);
        chk("stream_occ_drained", 32'(occupancy), 32'd0);
        chk("stream_q_empty", 32'(q.size()), 32'd0);
        step();

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; push(32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        chk("bp_in_ready0", 32'(in_ready), 32'd1);
        step();
        in_data = 32'h5A5A5A5A; push(32'h5A5A5A5A, 1'b0);
        @(negedge clk);
        chk("bp_in_ready1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_out_data", out_data, 32'hA5A5A5A5);
        step();
        @(negedge clk);
        chk("bp_out_data_held", out_data, 32'hA5A5A5A5);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_data", out_data, 32'h5A5A5A5A);
        chk("bp_occ_after", 32'(occupancy), 32'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_occ_drained", 32'(occupancy), 32'd0);
        step();

        // bubble collapse on DEPTH=4
        in_valid4 = 1'b1; in_data4 = 32'hDEAD;
        @(negedge clk);
        chk("bub_in_ready_acc", 32'(in_ready4), 32'd1);
        step();
        in_valid4 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bub_in_ready", 32'(in_ready4), 32'd1);
            chk("bub_occ", 32'(occupancy4), 32'd1);
            chk("bub_out_valid_early", 32'(out_valid4), 32'd0);
            step();
        end
        @(negedge clk);
        chk("bub_out_valid", 32'(out_valid4), 32'd1);
        chk("bub_out_data", out_data4, 32'hDEAD);
        chk("bub_occ_end", 32'(occupancy4), 32'd1);
        chk("bub_in_ready_end", 32'(in_ready4), 32'd1);
        step();
        out_ready4 = 1'b1;
        @(negedge clk);
        step();
        out_ready4 = 1'b0;
        @(negedge clk);
        chk("bub_occ_drained", 32'(occupancy4), 32'd0);
        chk("bub_out_valid_drained", 32'(out_valid4), 32'd0);
        step();

        // flush with a full pipe
        in_valid = 1'b1; in_data = 32'h01; push(32'h01, 1'b0);
        step();
        in_data = 32'h02; push(32'h02, 1'b0);
        step();
        flush = 1'b1; in_data = 32'h77;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_occ_before", 32'(occupancy), 32'd2);
        step();
        flush = 1'b0; in_valid = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_q_empty", 32'(q.size()), 32'd0);
        step();

        // parity
        in_valid = 1'b1; in_data = 32'h0000000F; err_inj = 1'b1; push(32'h0000000F, 1'b1);
        step();
        err_inj = 1'b0; push(32'h0000000F, 1'b0);
        step();
        in_valid = 1'b0;
        step(); step();
        @(negedge clk);
        chk("parity_q_empty", 32'(q.size()), 32'd0);
        step();

        // asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; push(32'h55, 1'b0);
        step();
        in_data = 32'h66; push(32'h66, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        chk("mid_out_valid_pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_occ", 32'(occupancy), 32'd0);
        chk("mid_out_data", out_data, 32'd0);
        q.delete();
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_occ", 32'(occupancy), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("final_q_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
